// File: rtl/if_stage_pkg.sv
// ----------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the instruction-fetch stage:
//   INSTR_WIDTH       instruction / operand width
//   NOP_INSTR         encoding placed in IF/ID when it holds no instruction
//   RESET_PC_DEFAULT  default first fetch address after reset
//   if_state_t        fetch FSM states (ISSUE / WAIT / HOLD / DROP)
//   redirect_taken()  decode-side redirect decision shared with if_next_pc
// ----------------------------------------------------------------------------
package if_stage_pkg;

  localparam int INSTR_WIDTH = 32;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = '0;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // ISSUE: send a request for pc
  // WAIT : one request outstanding, waiting for its response
  // HOLD : response arrived during a stall and sits in the skid register
  // DROP : outstanding response belongs to the wrong path and is discarded
  typedef enum logic [1:0] {
    IF_ISSUE = 2'd0,
    IF_WAIT  = 2'd1,
    IF_HOLD  = 2'd2,
    IF_DROP  = 2'd3
  } if_state_t;

  // Decode operands are stale while the hazard unit holds the pipe, so a
  // redirect is only honoured for a valid, unstalled instruction.
  function automatic logic redirect_taken(input logic valid,
                                          input logic stall,
                                          input logic j_op,
                                          input logic branch_op,
                                          input logic operands_eq);
    return valid & ~stall & (j_op | (branch_op & operands_eq));
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// ----------------------------------------------------------------------------
// if_stage_if
// Instruction-memory request/response bus between the fetch stage and memory.
//   W_imem_req     one-cycle request pulse (fetch stage -> memory)
//   W_imem_addr    request address, valid with W_imem_req
//   W_imem_rdata   fetched instruction word (memory -> fetch stage)
//   W_imem_rvalid  response strobe, one per request, in request order
// Modports: master = fetch stage, slave = instruction memory.
// ----------------------------------------------------------------------------
interface if_stage_if #(
  parameter int ADDR_WIDTH = 32
);
  import if_stage_pkg::*;

  logic                   W_imem_req;
  logic [ADDR_WIDTH-1:0]  W_imem_addr;
  logic [INSTR_WIDTH-1:0] W_imem_rdata;
  logic                   W_imem_rvalid;

  modport master (
    output W_imem_req,
    output W_imem_addr,
    input  W_imem_rdata,
    input  W_imem_rvalid
  );

  modport slave (
    input  W_imem_req,
    input  W_imem_addr,
    output W_imem_rdata,
    output W_imem_rvalid
  );

endinterface

// File: rtl/if_next_pc.sv
// ----------------------------------------------------------------------------
// if_next_pc
// Combinational redirect decision and target for BEQ / J sitting in decode.
// Ports:
//   if_pc      PC of the instruction in IF/ID (decode)
//   if_valid   IF/ID holds a real instruction
//   stall      hazard-unit hold; suppresses the redirect
//   branch_op  decode holds BEQ
//   j_op       decode holds J (wins over BEQ)
//   rs_data    BEQ first operand
//   rt_data    BEQ second operand
//   imme       BEQ word offset, sign-extended
//   j_imme     J word index
//   taken      redirect this cycle
//   target     redirect address
// Targets are relative to pc+4 of the decode instruction (no delay slot).
// ----------------------------------------------------------------------------
module if_next_pc
  import if_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0]  if_pc,
  input  logic                   if_valid,
  input  logic                   stall,
  input  logic                   branch_op,
  input  logic                   j_op,
  input  logic [INSTR_WIDTH-1:0] rs_data,
  input  logic [INSTR_WIDTH-1:0] rt_data,
  input  logic [15:0]            imme,
  input  logic [25:0]            j_imme,
  output logic                   taken,
  output logic [ADDR_WIDTH-1:0]  target
);

  logic [ADDR_WIDTH-1:0]  id_pc4;
  logic [ADDR_WIDTH-1:0]  br_offset;
  logic [ADDR_WIDTH-1:0]  br_target;
  logic [ADDR_WIDTH-1:0]  j_target;
  logic [INSTR_WIDTH-1:0] operand_diff;
  logic                   operands_eq;

  genvar gi;
  generate
    for (gi = 0; gi < INSTR_WIDTH; gi++) begin : g_cmp
      assign operand_diff[gi] = rs_data[gi] ^ rt_data[gi];
    end
  endgenerate

  assign operands_eq = ~|operand_diff;

  assign id_pc4    = if_pc + ADDR_WIDTH'(4);
  assign br_offset = {{(ADDR_WIDTH-18){imme[15]}}, imme, 2'b00};
  assign br_target = id_pc4 + br_offset;
  // J keeps the upper region bits of pc+4 and replaces the rest.
  assign j_target  = {id_pc4[ADDR_WIDTH-1:28], j_imme, 2'b00};

  assign taken  = redirect_taken(if_valid, stall, j_op, branch_op, operands_eq);
  assign target = j_op ? j_target : br_target;

endmodule

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, keeps at most one request outstanding to instruction memory,
// buffers a response that lands during a stall, and applies BEQ/J redirects
// from decode (no delay slot: wrong-path work is flushed or dropped).
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   W_stall         hazard hold; freezes PC and IF/ID
//   W_ID_branch_op  decode holds BEQ
//   W_ID_j_op       decode holds J
//   W_ID_rs_data    decode rs operand
//   W_ID_rt_data    decode rt operand
//   W_ID_imme       decode immediate
//   W_j_imme        decode jump index
//   imem            instruction-memory bus (master side)
//   W_IF_instr      IF/ID instruction, NOP when not valid
//   W_IF_pc         PC of W_IF_instr
//   W_IF_valid      IF/ID holds a real instruction
//   W_IF_redirect   combinational: redirect taken this cycle
// Optional (macro IF_PERF_CNT_EN):
//   W_perf_fetch_cnt   IF/ID loads of a valid instruction
//   W_perf_bubble_cnt  unstalled cycles that end with IF/ID empty
// ----------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   W_stall,
  input  logic                   W_ID_branch_op,
  input  logic                   W_ID_j_op,
  input  logic [INSTR_WIDTH-1:0] W_ID_rs_data,
  input  logic [INSTR_WIDTH-1:0] W_ID_rt_data,
  input  logic [15:0]            W_ID_imme,
  input  logic [25:0]            W_j_imme,
  if_stage_if.master             imem,
  output logic [INSTR_WIDTH-1:0] W_IF_instr,
  output logic [ADDR_WIDTH-1:0]  W_IF_pc,
  output logic                   W_IF_valid,
  output logic                   W_IF_redirect
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]            W_perf_fetch_cnt,
  output logic [31:0]            W_perf_bubble_cnt
`endif
);

  if_state_t              state_reg;
  logic [ADDR_WIDTH-1:0]  pc_reg;
  logic [INSTR_WIDTH-1:0] skid_reg;
  logic [INSTR_WIDTH-1:0] if_instr_reg;
  logic [ADDR_WIDTH-1:0]  if_pc_reg;
  logic                   if_valid_reg;

  logic [ADDR_WIDTH-1:0]  pc_plus4;
  logic                   redirect;
  logic [ADDR_WIDTH-1:0]  redirect_target;
  logic                   issue_req;
  logic [ADDR_WIDTH-1:0]  issue_addr;

  assign pc_plus4 = pc_reg + ADDR_WIDTH'(4);

  if_next_pc #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next_pc (
    .if_pc     (if_pc_reg),
    .if_valid  (if_valid_reg),
    .stall     (W_stall),
    .branch_op (W_ID_branch_op),
    .j_op      (W_ID_j_op),
    .rs_data   (W_ID_rs_data),
    .rt_data   (W_ID_rt_data),
    .imme      (W_ID_imme),
    .j_imme    (W_j_imme),
    .taken     (redirect),
    .target    (redirect_target)
  );

  // The next request goes out in the same cycle its predecessor's response
  // is consumed, which is what lets a 1-cycle memory sustain one fetch per
  // clock. Because of that the request is decoded combinationally.
  always_comb begin
    issue_req  = 1'b0;
    issue_addr = pc_reg;
    case (state_reg)
      IF_ISSUE: issue_req = 1'b1;
      IF_WAIT: begin
        if (imem.W_imem_rvalid) begin
          if (redirect) begin
            issue_req  = 1'b1;
            issue_addr = redirect_target;
          end else if (!W_stall) begin
            issue_req  = 1'b1;
            issue_addr = pc_plus4;
          end
        end
      end
      IF_HOLD: begin
        if (!W_stall && !redirect) begin
          issue_req  = 1'b1;
          issue_addr = pc_plus4;
        end
      end
      default: ;
    endcase
  end

  // Reset parks the FSM in ISSUE; masking with rst keeps the bus quiet
  // until reset is released.
  assign imem.W_imem_req  = issue_req & rst;
  assign imem.W_imem_addr = issue_addr;

  // pc_reg is the address of the fetch in flight (or about to be issued);
  // it advances when that fetch's instruction enters IF/ID.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IF_ISSUE;
      pc_reg       <= RESET_PC;
      skid_reg     <= NOP_INSTR;
      if_instr_reg <= NOP_INSTR;
      if_pc_reg    <= '0;
      if_valid_reg <= 1'b0;
    end else if (redirect) begin
      if_valid_reg <= 1'b0;
      if_instr_reg <= NOP_INSTR;
      pc_reg       <= redirect_target;
      if (state_reg == IF_WAIT && !imem.W_imem_rvalid) begin
        state_reg <= IF_DROP;
      end else if (state_reg == IF_HOLD) begin
        state_reg <= IF_ISSUE;
      end
    end else begin
      case (state_reg)
        IF_ISSUE: begin
          // Any response here predates reset; nothing is outstanding yet.
          state_reg <= IF_WAIT;
          if (!W_stall) begin
            if_valid_reg <= 1'b0;
            if_instr_reg <= NOP_INSTR;
          end
        end
        IF_WAIT: begin
          if (imem.W_imem_rvalid) begin
            if (W_stall) begin
              skid_reg  <= imem.W_imem_rdata;
              state_reg <= IF_HOLD;
            end else begin
              if_instr_reg <= imem.W_imem_rdata;
              if_pc_reg    <= pc_reg;
              if_valid_reg <= 1'b1;
              pc_reg       <= pc_plus4;
            end
          end else if (!W_stall) begin
            if_valid_reg <= 1'b0;
            if_instr_reg <= NOP_INSTR;
          end
        end
        IF_HOLD: begin
          if (!W_stall) begin
            if_instr_reg <= skid_reg;
            if_pc_reg    <= pc_reg;
            if_valid_reg <= 1'b1;
            pc_reg       <= pc_plus4;
            state_reg    <= IF_WAIT;
          end
        end
        IF_DROP: begin
          if (imem.W_imem_rvalid) begin
            state_reg <= IF_ISSUE;
          end
          if (!W_stall) begin
            if_valid_reg <= 1'b0;
            if_instr_reg <= NOP_INSTR;
          end
        end
        default: state_reg <= IF_ISSUE;
      endcase
    end
  end

  assign W_IF_instr    = if_instr_reg;
  assign W_IF_pc       = if_pc_reg;
  assign W_IF_valid    = if_valid_reg;
  assign W_IF_redirect = redirect;

`ifdef IF_PERF_CNT_EN
  logic        if_load;
  logic [31:0] perf_fetch_reg;
  logic [31:0] perf_bubble_reg;

  // IF/ID receives a valid instruction exactly on these conditions.
  always_comb begin
    if_load = ~redirect & ~W_stall &
              (((state_reg == IF_WAIT) & imem.W_imem_rvalid) |
               (state_reg == IF_HOLD));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_reg  <= '0;
      perf_bubble_reg <= '0;
    end else begin
      if (if_load) begin
        perf_fetch_reg <= perf_fetch_reg + 32'd1;
      end
      if (!W_stall && !if_load) begin
        perf_bubble_reg <= perf_bubble_reg + 32'd1;
      end
    end
  end

  assign W_perf_fetch_cnt  = perf_fetch_reg;
  assign W_perf_bubble_cnt = perf_bubble_reg;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage
// Directed bench for if_stage: a per-cycle vector table covering sequential
// fetch, a stall with a buffered response, a taken/untaken BEQ and a BEQ
// under stall, then hand-written sequences for J with a slow memory and for
// reset while a request is in flight. The memory responder returns
// 32'hC000_0000 | addr after a configurable latency.
// ----------------------------------------------------------------------------
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        W_stall = 1'b0;
  logic        W_ID_branch_op = 1'b0;
  logic        W_ID_j_op = 1'b0;
  logic [31:0] W_ID_rs_data = '0;
  logic [31:0] W_ID_rt_data = '0;
  logic [15:0] W_ID_imme = '0;
  logic [25:0] W_j_imme = '0;
  logic [31:0] W_IF_instr;
  logic [31:0] W_IF_pc;
  logic        W_IF_valid;
  logic        W_IF_redirect;
`ifdef IF_PERF_CNT_EN
  logic [31:0] W_perf_fetch_cnt;
  logic [31:0] W_perf_bubble_cnt;
`endif

  always #5 clk = ~clk;

  if_stage_if #(.ADDR_WIDTH(32)) imem ();

  if_stage #(
    .ADDR_WIDTH (32),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .W_stall        (W_stall),
    .W_ID_branch_op (W_ID_branch_op),
    .W_ID_j_op      (W_ID_j_op),
    .W_ID_rs_data   (W_ID_rs_data),
    .W_ID_rt_data   (W_ID_rt_data),
    .W_ID_imme      (W_ID_imme),
    .W_j_imme       (W_j_imme),
    .imem           (imem),
    .W_IF_instr     (W_IF_instr),
    .W_IF_pc        (W_IF_pc),
    .W_IF_valid     (W_IF_valid),
    .W_IF_redirect  (W_IF_redirect)
`ifdef IF_PERF_CNT_EN
    ,
    .W_perf_fetch_cnt  (W_perf_fetch_cnt),
    .W_perf_bubble_cnt (W_perf_bubble_cnt)
`endif
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hC000_0000 | a;
  endfunction

  // ---------------- memory responder ----------------
  typedef struct {
    int          due;
    logic [31:0] addr;
  } rsp_t;

  rsp_t        rsp_q[$];
  int          cyc = 0;
  int          mem_lat = 1;
  logic        req_seen = 1'b0;
  logic [31:0] addr_seen = '0;

  initial begin
    imem.W_imem_rvalid = 1'b0;
    imem.W_imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (req_seen) rsp_q.push_back('{due: cyc - 1 + mem_lat, addr: addr_seen});
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        imem.W_imem_rvalid = 1'b1;
        imem.W_imem_rdata  = word_of(rsp_q[0].addr);
        void'(rsp_q.pop_front());
      end else begin
        imem.W_imem_rvalid = 1'b0;
        imem.W_imem_rdata  = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      #2;
      req_seen  = imem.W_imem_req;
      addr_seen = imem.W_imem_addr;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imme;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_redir;
  } vec_t;

  function automatic vec_t mk(input logic stall, input logic br,
                              input logic [31:0] rs, input logic [31:0] rt,
                              input logic [15:0] imme,
                              input logic req, input logic [31:0] addr,
                              input logic valid, input logic [31:0] pc,
                              input logic [31:0] instr, input logic redir);
    vec_t v;
    v.stall = stall; v.br = br; v.rs = rs; v.rt = rt; v.imme = imme;
    v.exp_req = req; v.exp_addr = addr; v.exp_valid = valid;
    v.exp_pc = pc; v.exp_instr = instr; v.exp_redir = redir;
    return v;
  endfunction

  localparam int NV = 15;
  vec_t vecs[NV];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;

    //        stall br rs  rt  imme      req addr    valid pc     instr            redir
    vecs[0]  = mk(0, 0, 0, 0, 16'h0,    1, 32'h00, 0, 32'h0,  32'h0,           0);
    vecs[1]  = mk(0, 0, 0, 0, 16'h0,    1, 32'h04, 0, 32'h0,  32'h0,           0);
    vecs[2]  = mk(0, 0, 0, 0, 16'h0,    1, 32'h08, 1, 32'h00, word_of(32'h00), 0);
    vecs[3]  = mk(1, 0, 0, 0, 16'h0,    0, 32'h00, 1, 32'h04, word_of(32'h04), 0);
    vecs[4]  = mk(1, 0, 0, 0, 16'h0,    0, 32'h00, 1, 32'h04, word_of(32'h04), 0);
    vecs[5]  = mk(1, 0, 0, 0, 16'h0,    0, 32'h00, 1, 32'h04, word_of(32'h04), 0);
    vecs[6]  = mk(0, 0, 0, 0, 16'h0,    1, 32'h0C, 1, 32'h04, word_of(32'h04), 0);
    vecs[7]  = mk(0, 0, 0, 0, 16'h0,    1, 32'h10, 1, 32'h08, word_of(32'h08), 0);
    vecs[8]  = mk(0, 0, 0, 0, 16'h0,    1, 32'h14, 1, 32'h0C, word_of(32'h0C), 0);
    vecs[9]  = mk(0, 1, 5, 5, 16'hFFFC, 1, 32'h04, 1, 32'h10, word_of(32'h10), 1);
    vecs[10] = mk(0, 0, 0, 0, 16'h0,    1, 32'h08, 0, 32'h0,  32'h0,           0);
    vecs[11] = mk(0, 1, 1, 2, 16'hFFFC, 1, 32'h0C, 1, 32'h04, word_of(32'h04), 0);
    vecs[12] = mk(1, 1, 7, 7, 16'hFFFC, 0, 32'h00, 1, 32'h08, word_of(32'h08), 0);
    vecs[13] = mk(0, 0, 0, 0, 16'h0,    1, 32'h10, 1, 32'h08, word_of(32'h08), 0);
    vecs[14] = mk(0, 0, 0, 0, 16'h0,    1, 32'h14, 1, 32'h0C, word_of(32'h0C), 0);

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   {31'b0, imem.W_imem_req}, 32'd0);
    chk("rst_valid", {31'b0, W_IF_valid}, 32'd0);
    chk("rst_instr", W_IF_instr, 32'h0);
    chk("rst_pc",    W_IF_pc, 32'h0);
    chk("rst_redir", {31'b0, W_IF_redirect}, 32'd0);

    // ---- vector table: fetch, stall/skid, BEQ taken/untaken/stalled ----
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < NV; i++) begin
      if (i != 0) begin
        @(posedge clk);
        #1;
      end
      W_stall        = vecs[i].stall;
      W_ID_branch_op = vecs[i].br;
      W_ID_rs_data   = vecs[i].rs;
      W_ID_rt_data   = vecs[i].rt;
      W_ID_imme      = vecs[i].imme;
      @(negedge clk);
      $display("row %0d: req=%b addr=%h valid=%b pc=%h instr=%h redirect=%b",
               i, imem.W_imem_req, imem.W_imem_addr, W_IF_valid, W_IF_pc,
               W_IF_instr, W_IF_redirect);
      chk($sformatf("r%0d_req", i), {31'b0, imem.W_imem_req}, {31'b0, vecs[i].exp_req});
      if (vecs[i].exp_req) chk($sformatf("r%0d_addr", i), imem.W_imem_addr, vecs[i].exp_addr);
      chk($sformatf("r%0d_valid", i), {31'b0, W_IF_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) chk($sformatf("r%0d_pc", i), W_IF_pc, vecs[i].exp_pc);
      chk($sformatf("r%0d_instr", i), W_IF_instr, vecs[i].exp_instr);
      chk($sformatf("r%0d_redir", i), {31'b0, W_IF_redirect}, {31'b0, vecs[i].exp_redir});
    end

    // ---- J with 3-cycle memory: response pending -> DROP ----
    @(posedge clk);
    #1;
    rst = 1'b0;
    W_stall = 1'b0; W_ID_branch_op = 1'b0; W_ID_rs_data = '0; W_ID_rt_data = '0; W_ID_imme = '0;
    repeat (2) @(posedge clk);
    #1;
    mem_lat = 3;
    rst = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (W_IF_valid && W_IF_pc == 32'h20) found = 1'b1;
    end
    chk("j_reach_0x20", {31'b0, found}, 32'd1);
    W_ID_j_op = 1'b1;
    W_j_imme  = 26'h40;
    #1;
    $display("J at pc=%h: redirect=%b req=%b", W_IF_pc, W_IF_redirect, imem.W_imem_req);
    chk("j_redir", {31'b0, W_IF_redirect}, 32'd1);
    chk("j_req_hold", {31'b0, imem.W_imem_req}, 32'd0);
    @(posedge clk);
    #1;
    W_ID_j_op = 1'b0;
    W_j_imme  = '0;
    @(negedge clk);
    chk("drop1_redir", {31'b0, W_IF_redirect}, 32'd0);
    chk("drop1_req",   {31'b0, imem.W_imem_req}, 32'd0);
    chk("drop1_valid", {31'b0, W_IF_valid}, 32'd0);
    chk("drop1_instr", W_IF_instr, 32'h0);
    @(negedge clk);
    chk("drop2_req",   {31'b0, imem.W_imem_req}, 32'd0);
    chk("drop2_valid", {31'b0, W_IF_valid}, 32'd0);
    @(negedge clk);
    $display("after drop: req=%b addr=%h valid=%b", imem.W_imem_req, imem.W_imem_addr, W_IF_valid);
    chk("jtgt_req",   {31'b0, imem.W_imem_req}, 32'd1);
    chk("jtgt_addr",  imem.W_imem_addr, 32'h100);
    chk("jtgt_valid", {31'b0, W_IF_valid}, 32'd0);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (W_IF_valid) found = 1'b1;
    end
    chk("jtgt_loaded", {31'b0, found}, 32'd1);
    chk("jtgt_pc",    W_IF_pc, 32'h100);
    chk("jtgt_instr", W_IF_instr, word_of(32'h100));

    // ---- reset while a request is outstanding; late response ignored ----
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (imem.W_imem_req) found = 1'b1;
    end
    chk("rr_find_req", {31'b0, found}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rr_req",   {31'b0, imem.W_imem_req}, 32'd0);
    chk("rr_valid", {31'b0, W_IF_valid}, 32'd0);
    chk("rr_instr", W_IF_instr, 32'h0);
    chk("rr_pc",    W_IF_pc, 32'h0);
    chk("rr_redir", {31'b0, W_IF_redirect}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;   // first cycle out of reset coincides with the late response
    @(negedge clk);
    $display("post reset: req=%b addr=%h late_rvalid=%b", imem.W_imem_req, imem.W_imem_addr, imem.W_imem_rvalid);
    chk("pr_req",   {31'b0, imem.W_imem_req}, 32'd1);
    chk("pr_addr",  imem.W_imem_addr, 32'h0);
    chk("pr_valid", {31'b0, W_IF_valid}, 32'd0);
    @(negedge clk);
    chk("pr1_req",   {31'b0, imem.W_imem_req}, 32'd0);
    chk("pr1_valid", {31'b0, W_IF_valid}, 32'd0);
    @(negedge clk);
    chk("pr2_req",   {31'b0, imem.W_imem_req}, 32'd0);
    chk("pr2_valid", {31'b0, W_IF_valid}, 32'd0);
    @(negedge clk);
    chk("pr3_req",   {31'b0, imem.W_imem_req}, 32'd1);
    chk("pr3_addr",  imem.W_imem_addr, 32'h4);
    chk("pr3_valid", {31'b0, W_IF_valid}, 32'd0);
    @(negedge clk);
    $display("first post-reset fetch: valid=%b pc=%h instr=%h", W_IF_valid, W_IF_pc, W_IF_instr);
    chk("pr4_valid", {31'b0, W_IF_valid}, 32'd1);
    chk("pr4_pc",    W_IF_pc, 32'h0);
    chk("pr4_instr", W_IF_instr, word_of(32'h0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage with IF/ID pipeline register; feeds W_IF_instr to the decode stage.
- Owns the PC and runs a single-outstanding request/response handshake to instruction memory.
- Holds fetched instructions under hazard stalls.
- Resolves BEQ/J redirects from decode, with no delay slot: the wrong-path instruction is flushed and any in-flight fetch is dropped.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
ADDR_WIDTH, 32, PC/address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
W_stall  in  1  hazard-unit hold (load-use); freezes PC and IF/ID register
W_ID_branch_op  in  1  decode holds BEQ
W_ID_j_op  in  1  decode holds J
W_ID_rs_data  in  `INSTR_WIDTH  decode rs operand
W_ID_rt_data  in  `INSTR_WIDTH  decode rt operand
W_ID_imme  in  16  decode immediate
W_j_imme  in  26  decode jump index
W_imem_req  out  1  one-cycle fetch request pulse
W_imem_addr  out  ADDR_WIDTH  fetch address, valid with W_imem_req
W_imem_rdata  in  `INSTR_WIDTH  fetched word
W_imem_rvalid  in  1  response strobe; exactly one per request, at least 1 cycle after it
W_IF_instr  out  `INSTR_WIDTH  IF/ID instruction; 32'h0 (NOP) when not valid
W_IF_pc  out  ADDR_WIDTH  PC of W_IF_instr
W_IF_valid  out  1  IF/ID holds a real instruction
W_IF_redirect  out  1  combinational: redirect taken this cycle

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=ISSUE, IF/ID valid=0, instr=0, IF_pc=0, skid empty, W_imem_req=0.
- First req: issued in the first clock after rst deasserts.
- States:
  - ISSUE: pulse req, addr=pc; go to WAIT.
  - WAIT: awaiting rvalid.
  - HOLD: response buffered in skid register while stalled.
  - DROP: discard the next rvalid.
- Redirect condition: taken = W_IF_valid & ~W_stall & (W_ID_j_op | (W_ID_branch_op & rs_data==rt_data)). Redirect is never taken while stalled, because decode operands are stale.
- Targets use ID_pc4 = W_IF_pc+4:
  - branch target = ID_pc4 + (sext(W_ID_imme)<<2)
  - jump target = {ID_pc4[31:28], W_j_imme, 2'b00}
  - J has priority if both ops are set.
- WAIT, rvalid, no stall, no redirect: IF/ID <= {rdata, pc, 1}; pc += 4; a new req to pc+4 is issued in the same cycle. With 1-cycle memory this sustains one instruction per clock.
- WAIT, rvalid, stall: IF/ID unchanged; rdata goes to the skid register; go to HOLD.
- HOLD, stall released: IF/ID <= skid; pc += 4; req to pc+4; go to WAIT.
- WAIT, no rvalid, no stall: IF/ID valid <= 0 and instr <= 0 (bubble).
- Stall with no response: IF/ID holds its contents.
- Redirect has priority over everything else in the same cycle:
  - IF/ID is flushed (valid=0, instr=0) and pc <= target.
  - WAIT, no rvalid this cycle: go to DROP; the next rvalid is discarded, then req to target.
  - WAIT with rvalid in the same cycle: the response is discarded and req to target is issued that cycle.
  - HOLD: the skid register is discarded and req to target is issued next cycle.
- W_imem_req never asserts while a request is outstanding; response order is guaranteed.
- PC arithmetic wraps modulo 2^ADDR_WIDTH; no alignment trap is raised.
- Reset mid-request: the late response is ignored. Post-reset state ISSUE has no outstanding request, so any rvalid arriving there is discarded.

Optional Feature:
IF_PERF_CNT_EN:
- Defined: adds outputs W_perf_fetch_cnt[31:0] and W_perf_bubble_cnt[31:0], both reset to 0.
  - W_perf_fetch_cnt counts IF/ID loads with valid=1.
  - W_perf_bubble_cnt counts cycles ending with valid=0 and no stall.
  - Both wrap at 2^32.
- Undefined: ports and logic are absent; the core is otherwise identical.

Decomposition:
- defines.v gains `RESET_PC, `NOP_INSTR (32'h0), the 2-bit IF state encodings (ISSUE/WAIT/HOLD/DROP), and reuses `BEQ_OP_CODE/`J_OP_CODE.
- One sub-module, if_next_pc: combinational branch/jump target and taken logic. FSM and registers stay in if_stage.

Test Plan:
1. Reset, 1-cycle memory returning addr-derived words -> req at 0x0,0x4,0x8 on consecutive clocks; W_IF_pc 0,4,8 with valid=1, one per clock.
2. Assert W_stall 3 cycles while rvalid arrives for 0x8 -> IF/ID holds 0x4 instr; 0x8 loaded on the first unstalled cycle; no req while held.
3. BEQ at pc 0x10, imme=16'hFFFC, rs=rt=5 -> redirect=1; next req addr 0x4; wrong-path 0x14 flushed (valid=0, instr=0).
4. J at pc 0x20, j_imme=26'h40, with 3-cycle memory, response pending -> DROP; stale word discarded; next req addr 0x100.
5. BEQ with rs!=rt, then BEQ with rs=rt while W_stall=1 -> no redirect in either case; sequential fetch continues.
6. Assert rst low mid-WAIT, release -> outputs at reset values; first req addr RESET_PC; late rvalid ignored.
